dram_read_master: RTL and testbench
===================================

// Module: dram_read_master
// PURPOSE
//  AXI4 read master answering the ImageSender DRAM read request port (dram_read_addr/len/en).
//  Turns one request into one or two INCR bursts on the PS DDR HP port, split at a 4 KB page.
//  Returns beats in order on dram_read_data/dram_read_data_valid.
//  Honours dram_buffer_full back-pressure.
//  Sits between ImageController and the HP slave port, in the same clock domain as the AXI slave.
// PARAMETERS
//  DRAM_ADDR_WIDTH  39   byte address width of the request and of m_axi_araddr
//  DRAM_DATA_WIDTH  128  data width; fixed 16 B beats (arsize=3'b100)
//  AXI_ID_WIDTH     6    width of m_axi_arid/m_axi_rid; ID driven as all-zero
// PORTS
//  m_axi_aclk            in   1    single clock; all logic on rising edge
//  m_axi_areset          in   1    reset, asynchronous assert, active-high
//  dram_read_addr        in   39   start byte address; bits[3:0] ignored (forced 0)
//  dram_read_len         in   8    beats-1 (AXI encoding), 0..255
//  dram_read_en          in   1    1-cycle request strobe
//  dram_buffer_full      in   1    consumer cannot take more beats (asserted with >=1 entry headroom)
//  dram_read_busy        out  1    request in progress
//  dram_read_data        out  128  returned beat
//  dram_read_data_valid  out  1    1-cycle qualifier per beat
//  dram_read_error       out  1    sticky: SLVERR/DECERR or RLAST mismatch seen
//  m_axi_araddr          out  39   AR address
//  m_axi_arlen           out  8    AR length
//  m_axi_arid            out  ID   constant 0
//  m_axi_arburst/arsize/arcache/arprot  out  2/3/4/3  constants 01/100/0011/000
//  m_axi_arvalid         out  1    AR valid
//  m_axi_arready         in   1    AR ready
//  m_axi_rdata           in   128  R data
//  m_axi_rresp           in   2    R response
//  m_axi_rlast           in   1    R last
//  m_axi_rid             in   ID   R ID (ignored)
//  m_axi_rvalid          in   1    R valid
//  m_axi_rready          out  1    R ready
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (busy, valid, error, arvalid, rready, araddr, arlen, data).
//  FSM IDLE -> AR1 -> R1 -> [AR2 -> R2] -> IDLE.
//  IDLE: dram_read_en latches addr/len.
//    - Cycle N+1: busy=1, state AR1, error cleared.
//    - page_beats = 256 - addr[11:4]. If len+1 <= page_beats: single burst (len1=len).
//    - Otherwise: len1 = page_beats-1; len2 = len-page_beats; addr2 = {addr[38:12]+1, 12'h0}.
//  dram_read_en while busy: ignored, request dropped, error unaffected (caller polls busy).
//  AR1/AR2: arvalid=1 with stable addr/len until arready; the handshake cycle moves to R1/R2.
//  R1/R2:
//    - rready = ~dram_buffer_full (combinational).
//    - Each rvalid&rready beat: data/valid registered, appearing next cycle (1-cycle latency).
//    - Beat counter counts down.
//  R-phase exit on the rlast handshake:
//    - R1 -> AR2 if split, else IDLE.
//    - R2 -> IDLE.
//  busy drops in the cycle the final data_valid is presented; en may be accepted that same cycle.
//  rresp!=OKAY on any beat: sets error; data still forwarded; burst completes normally.
//  RLAST mismatch: rlast before counter hits 0, or counter 0 without rlast, sets error.
//    - FSM advances only on rlast.
//  Only one outstanding AR at a time; no read reordering needed (single ID).
//  Address arithmetic 39-bit wrap: page carry out of bit 38 discarded.
//  Reset mid-burst drops everything; the HP port must share the same reset domain.
// STRUCTURE
//  Shared package image_dram_pkg:
//    - AXI constants BURST_INCR, SIZE_16B, CACHE_MODIFIABLE, PAGE_BYTES=4096.
//    - enum rd_state_t {IDLE,AR1,R1,AR2,R2}.
//    - function split_burst(addr,len) returning len1/len2/addr2/split.
//  No sub-module; the FSM and a 1-stage output register live in one module.
// TESTING
//  1. addr=0x1000_0000, len=15, rready always -> 1 AR (len 15), 16 valid beats, busy low after beat 16.
//  2. addr=0x0000_0F80, len=15 -> AR1 addr 0xF80 len 7, then AR2 addr 0x1000 len 7; 16 beats in order.
//  3. len=255, addr page-aligned, dram_buffer_full toggled every 3 cycles -> rready mirrors ~full; 256 beats, no loss/dup.
//  4. rresp=2'b10 on beat 5 of 8 -> dram_read_error=1 after beat 5, all 8 beats delivered; next en clears error.
//  5. en pulsed while busy -> ignored, single burst only; en on busy-fall cycle -> accepted, arvalid next cycle.
//  6. m_axi_areset asserted mid-R1 -> all outputs 0 immediately; after release, a fresh request completes.

Source files
------------

// File: rtl/image_dram_pkg.sv
// ============================================================================
// Module      : image_dram_pkg
// Description : Shared AXI constants, read-master state encoding and the
//               4 KB page split helper for the ImageSender DRAM path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package image_dram_pkg;

    localparam int DRAM_ADDR_W = 39;
    localparam int PAGE_BYTES  = 4096;

    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [2:0] SIZE_16B         = 3'b100;
    localparam logic [3:0] CACHE_MODIFIABLE = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT     = 3'b000;
    localparam logic [1:0] RESP_OKAY        = 2'b00;

    localparam logic [DRAM_ADDR_W-13:0] PAGE_ONE = 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR1  = 3'd1;
    localparam logic [2:0] ST_R1   = 3'd2;
    localparam logic [2:0] ST_AR2  = 3'd3;
    localparam logic [2:0] ST_R2   = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        AR1  = ST_AR1,
        R1   = ST_R1,
        AR2  = ST_AR2,
        R2   = ST_R2
    } rd_state_t;

    typedef struct packed {
        logic                   split;
        logic [7:0]             len1;
        logic [7:0]             len2;
        logic [DRAM_ADDR_W-1:0] addr2;
    } split_t;

    // A burst that would cross a 4 KB boundary is cut into two INCR bursts;
    // the page carry out of the top address bit is discarded.
    function automatic split_t split_burst(input logic [DRAM_ADDR_W-1:0] addr,
                                           input logic [7:0]             len);
        split_t                  s;
        logic [8:0]              page_beats;
        logic [8:0]              beats;
        logic [DRAM_ADDR_W-13:0] page_hi;
        page_beats = 9'(PAGE_BYTES / 16) - {1'b0, addr[11:4]};
        beats      = {1'b0, len} + 9'd1;
        page_hi    = addr[DRAM_ADDR_W-1:12] + PAGE_ONE;
        s.addr2    = {page_hi, 12'h000};
        if (beats <= page_beats) begin
            s.split = 1'b0;
            s.len1  = len;
            s.len2  = 8'd0;
        end else begin
            s.split = 1'b1;
            s.len1  = page_beats[7:0] - 8'd1;
            s.len2  = len - page_beats[7:0];
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram_read_master.sv
// ============================================================================
// Module      : dram_read_master
// Description : AXI4 read master turning one ImageSender DRAM request into one
//               or two page-bounded INCR bursts and returning beats in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_read_master
    import image_dram_pkg::*;
#(
    parameter int DRAM_ADDR_WIDTH = DRAM_ADDR_W,
    parameter int DRAM_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH    = 6
) (
    input  logic                       m_axi_aclk,
    input  logic                       m_axi_areset,

    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    input  logic                       dram_buffer_full,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_error,

    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
    output logic [1:0]                 m_axi_arburst,
    output logic [2:0]                 m_axi_arsize,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    rd_state_t                  r_state;
    logic                       r_busy;
    logic                       r_error;
    logic                       r_arvalid;
    logic [DRAM_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                 r_arlen;
    logic [DRAM_DATA_WIDTH-1:0] r_data;
    logic                       r_data_valid;
    logic                       r_split;
    logic [7:0]                 r_len2;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr2;
    logic [7:0]                 r_beat_cnt;

    logic [DRAM_ADDR_WIDTH-1:0] w_req_addr;
    split_t                     w_split;
    logic                       w_in_r;
    logic                       w_beat;
    logic                       w_beat_bad;
    logic                       w_unused_ok;

    assign w_req_addr = {dram_read_addr[DRAM_ADDR_WIDTH-1:4], 4'h0};
    assign w_split    = split_burst(w_req_addr, dram_read_len);
    assign w_in_r     = (r_state == R1) || (r_state == R2);
    assign w_beat     = m_axi_rvalid && m_axi_rready;
    // Flag a bad response or an RLAST that disagrees with the beat count.
    assign w_beat_bad = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != (r_beat_cnt == 8'd0));
    assign w_unused_ok = ^{m_axi_rid, dram_read_addr[3:0]};

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_split      <= 1'b0;
            r_len2       <= '0;
            r_addr2      <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_data_valid <= w_beat;
            if (w_beat) begin
                r_data <= m_axi_rdata;
                if (w_beat_bad) begin
                    r_error <= 1'b1;
                end
                if (r_beat_cnt != 8'd0) begin
                    r_beat_cnt <= r_beat_cnt - 8'd1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (dram_read_en) begin
                        r_state    <= AR1;
                        r_busy     <= 1'b1;
                        r_error    <= 1'b0;
                        r_arvalid  <= 1'b1;
                        r_araddr   <= w_req_addr;
                        r_arlen    <= w_split.len1;
                        r_beat_cnt <= w_split.len1;
                        r_split    <= w_split.split;
                        r_len2     <= w_split.len2;
                        r_addr2    <= w_split.addr2;
                    end
                end
                AR1: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= R1;
                    end
                end
                R1: begin
                    if (w_beat && m_axi_rlast) begin
                        if (r_split) begin
                            r_state    <= AR2;
                            r_arvalid  <= 1'b1;
                            r_araddr   <= r_addr2;
                            r_arlen    <= r_len2;
                            r_beat_cnt <= r_len2;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                AR2: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= R2;
                    end
                end
                R2: begin
                    if (w_beat && m_axi_rlast) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_axi_rready         = w_in_r && !dram_buffer_full;
    assign m_axi_arvalid        = r_arvalid;
    assign m_axi_araddr         = r_araddr;
    assign m_axi_arlen          = r_arlen;
    assign m_axi_arid           = '0;
    assign m_axi_arburst        = BURST_INCR;
    assign m_axi_arsize         = SIZE_16B;
    assign m_axi_arcache        = CACHE_MODIFIABLE;
    assign m_axi_arprot         = PROT_DEFAULT;
    assign dram_read_busy       = r_busy;
    assign dram_read_error      = r_error;
    assign dram_read_data       = r_data;
    assign dram_read_data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_dram_read_master.sv
// ============================================================================
// Module      : tb_dram_read_master
// Description : Scoreboard bench for dram_read_master with a small AXI read
//               slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_read_master;

    localparam int AW = 39;
    localparam int DW = 128;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] dram_read_addr   = '0;
    logic [7:0]    dram_read_len    = '0;
    logic          dram_read_en     = 1'b0;
    logic          dram_buffer_full = 1'b0;
    logic          dram_read_busy;
    logic [DW-1:0] dram_read_data;
    logic          dram_read_data_valid;
    logic          dram_read_error;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [IW-1:0] m_axi_arid;
    logic [1:0]    m_axi_arburst;
    logic [2:0]    m_axi_arsize;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata   = '0;
    logic [1:0]    m_axi_rresp   = '0;
    logic          m_axi_rlast   = 1'b0;
    logic [IW-1:0] m_axi_rid     = '0;
    logic          m_axi_rvalid  = 1'b0;
    logic          m_axi_rready;

    dram_read_master dut (
        .m_axi_aclk           (clk),
        .m_axi_areset         (rst),
        .dram_read_addr       (dram_read_addr),
        .dram_read_len        (dram_read_len),
        .dram_read_en         (dram_read_en),
        .dram_buffer_full     (dram_buffer_full),
        .dram_read_busy       (dram_read_busy),
        .dram_read_data       (dram_read_data),
        .dram_read_data_valid (dram_read_data_valid),
        .dram_read_error      (dram_read_error),
        .m_axi_araddr         (m_axi_araddr),
        .m_axi_arlen          (m_axi_arlen),
        .m_axi_arid           (m_axi_arid),
        .m_axi_arburst        (m_axi_arburst),
        .m_axi_arsize         (m_axi_arsize),
        .m_axi_arcache        (m_axi_arcache),
        .m_axi_arprot         (m_axi_arprot),
        .m_axi_arvalid        (m_axi_arvalid),
        .m_axi_arready        (m_axi_arready),
        .m_axi_rdata          (m_axi_rdata),
        .m_axi_rresp          (m_axi_rresp),
        .m_axi_rlast          (m_axi_rlast),
        .m_axi_rid            (m_axi_rid),
        .m_axi_rvalid         (m_axi_rvalid),
        .m_axi_rready         (m_axi_rready)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    bit            q_err[$];
    logic [AW-1:0] q_ar_addr[$];
    logic [7:0]    q_ar_len[$];

    bit            s_active   = 1'b0;
    logic [AW-1:0] s_addr     = '0;
    logic [7:0]    s_len      = '0;
    int            s_idx      = 0;
    bit            rv_hold    = 1'b0;
    int            g_beat     = 0;
    int            inject_idx = -1;
    bit            full_mode  = 1'b0;
    bit            gap_mode   = 1'b0;
    bit            slow_ar    = 1'b0;
    int            cyc        = 0;
    int            wait_n     = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        return {25'd0, a, a[24:0], a};
    endfunction

    // One clock: drive slave/back-pressure at negedge, then check and infer
    // which handshakes the next rising edge will complete.
    task automatic step();
        logic [DW-1:0] e_data;
        bit            e_last;
        bit            e_err;
        @(negedge clk);
        dram_buffer_full = full_mode && (((cyc / 3) % 2) == 1);
        m_axi_arready    = slow_ar ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (s_active) begin
            m_axi_rvalid = rv_hold || !gap_mode || ($urandom_range(0, 2) != 0);
            m_axi_rdata  = beat_data(s_addr + (AW'(s_idx) << 4));
            m_axi_rlast  = (s_idx == int'(s_len));
            m_axi_rresp  = (g_beat == inject_idx) ? 2'b10 : 2'b00;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
        end
        #1;
        if (dram_read_data_valid) begin
            if (q_data.size() == 0) begin
                check_val("unexpected_beat", 1, 0);
            end else begin
                e_data = q_data.pop_front();
                e_last = q_last.pop_front();
                e_err  = q_err.pop_front();
                check_val("data", dram_read_data, e_data);
                check_val("error_at_beat", dram_read_error, e_err);
                check_val("busy_at_beat", dram_read_busy, !e_last);
            end
        end
        if (s_active) check_val("rready", m_axi_rready, !dram_buffer_full);
        if (m_axi_rvalid && m_axi_rready) begin
            rv_hold = 1'b0;
            g_beat++;
            if (m_axi_rlast) s_active = 1'b0;
            else s_idx++;
        end else begin
            rv_hold = m_axi_rvalid;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            if (q_ar_addr.size() == 0) begin
                check_val("unexpected_ar", 1, 0);
            end else begin
                check_val("araddr", m_axi_araddr, q_ar_addr.pop_front());
                check_val("arlen", m_axi_arlen, q_ar_len.pop_front());
            end
            s_active = 1'b1;
            s_addr   = m_axi_araddr;
            s_len    = m_axi_arlen;
            s_idx    = 0;
        end
        cyc++;
    endtask

    task automatic flush();
        q_data.delete();
        q_last.delete();
        q_err.delete();
        q_ar_addr.delete();
        q_ar_len.delete();
        s_active = 1'b0;
        rv_hold  = 1'b0;
    endtask

    task automatic request(input logic [AW-1:0] a, input logic [7:0] l, input bit accept);
        logic [AW-1:0] a0;
        int beats;
        int to_page;
        int cap;
        a0 = {a[AW-1:4], 4'h0};
        dram_read_addr = a;
        dram_read_len  = l;
        dram_read_en   = 1'b1;
        if (accept) begin
            beats   = int'(l) + 1;
            to_page = 4096 - int'(a0[11:0]);
            cap     = to_page / 16;
            if (beats <= cap) begin
                q_ar_addr.push_back(a0);
                q_ar_len.push_back(l);
            end else begin
                q_ar_addr.push_back(a0);
                q_ar_len.push_back(8'(cap - 1));
                q_ar_addr.push_back(a0 + AW'(to_page));
                q_ar_len.push_back(8'(beats - cap - 1));
            end
            for (int i = 0; i < beats; i++) begin
                q_data.push_back(beat_data(a0 + (AW'(i) << 4)));
                q_last.push_back(i == beats - 1);
                q_err.push_back(inject_idx >= 0 && i >= inject_idx);
            end
            g_beat = 0;
        end
        step();
        dram_read_en = 1'b0;
        if (accept) begin
            check_val("busy_after_accept", dram_read_busy, 1);
            check_val("arvalid_after_accept", m_axi_arvalid, 1);
            check_val("error_after_accept", dram_read_error, 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q_data.size() != 0 || q_ar_addr.size() != 0 || s_active) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            check_val("timeout", 1, 0);
            flush();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, dram_read_busy, 0);
        check_val({tag, "_valid"}, dram_read_data_valid, 0);
        check_val({tag, "_error"}, dram_read_error, 0);
        check_val({tag, "_arvalid"}, m_axi_arvalid, 0);
        check_val({tag, "_rready"}, m_axi_rready, 0);
        check_val({tag, "_araddr"}, m_axi_araddr, 0);
        check_val({tag, "_arlen"}, m_axi_arlen, 0);
        check_val({tag, "_data"}, dram_read_data, 0);
    endtask

    initial begin
        step();
        step();
        check_all_zero("reset");
        check_val("arburst", m_axi_arburst, 2'b01);
        check_val("arsize", m_axi_arsize, 3'b100);
        check_val("arcache", m_axi_arcache, 4'b0011);
        rst = 1'b0;

        request(39'h00_1000_0000, 8'd15, 1'b1);
        wait_idle(500);
        request(39'h00_0000_0F80, 8'd15, 1'b1);
        wait_idle(500);
        request(39'h00_0000_0F80, 8'd7, 1'b1);
        wait_idle(500);
        request(39'h00_0000_0FF7, 8'd0, 1'b1);
        wait_idle(500);
        request(39'h7F_FFFF_FF00, 8'd31, 1'b1);
        wait_idle(500);

        full_mode = 1'b1;
        gap_mode  = 1'b1;
        slow_ar   = 1'b1;
        request(39'h00_2000_0000, 8'd255, 1'b1);
        wait_idle(4000);
        full_mode = 1'b0;
        gap_mode  = 1'b0;
        slow_ar   = 1'b0;

        inject_idx = 4;
        request(39'h00_3000_0040, 8'd7, 1'b1);
        wait_idle(500);
        inject_idx = -1;
        request(39'h00_3000_0100, 8'd3, 1'b1);
        wait_idle(500);

        request(39'h00_4000_0000, 8'd15, 1'b1);
        repeat (4) step();
        request(39'h00_5000_0000, 8'd3, 1'b0);
        wait_idle(500);
        request(39'h00_6000_0FC0, 8'd7, 1'b1);
        wait_idle(500);

        request(39'h00_7000_0000, 8'd31, 1'b1);
        wait_n = 0;
        while (!(s_active && s_idx >= 3) && wait_n < 200) begin
            step();
            wait_n++;
        end
        check_val("reached_mid_burst", (wait_n < 200), 1);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        flush();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        step();
        step();
        rst = 1'b0;
        request(39'h00_7000_0800, 8'd15, 1'b1);
        wait_idle(500);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
